heads_up_betting_ctrl: RTL and testbench
========================================

Name: heads_up_betting_ctrl

Overview:
- Sequences one heads-up betting street (pre-flop, flop, turn or river) for the poker hand FSM.
- Posts blinds on pre-flop streets and tracks whose turn it is, the per-player street contribution, the call amount and the minimum legal raise.
- Turns each validated user action into a single make_bet pulse toward the player stack datapath.
- Signals street completion, a fold or an all-in back to the hand FSM.

Parameters:
- MAX_STACK_W, 11, width of every chip quantity.
- SB_SIZE, 1, small blind in chips.
- BB_SIZE, 2, big blind in chips; also the minimum raise increment at street start.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  pulse; begin a street (accepted only in IDLE)
- preflop  in  1  sampled with start; 1 = post blinds first
- button  in  1  sampled with start; dealer/SB player index (0 = p1, 1 = p2)
- stack_p1, stack_p2  in  MAX_STACK_W  chips remaining at street start; sampled with start
- action_valid  in  1  pulse; one user action for the current actor
- action  in  2  0 = check/call, 1 = bet/raise, 2 = fold, 3 = reserved
- raise_to  in  MAX_STACK_W  actor's total street contribution after a raise
- actor  out  1  player to act
- call_amt  out  MAX_STACK_W  chips the actor needs to call (capped at the actor's remaining stack)
- min_raise_to  out  MAX_STACK_W  smallest legal raise_to
- make_bet  out  1  pulse; commit bet_amount from bet_player
- bet_player  out  1
- bet_amount  out  MAX_STACK_W  incremental chips
- street_pot  out  MAX_STACK_W  sum of both street contributions
- action_error  out  1  pulse; action rejected
- street_done  out  1  pulse; street finished
- fold_end  out  1  valid with street_done; hand ended by fold
- winner  out  1  valid when fold_end; the non-folding player
- all_in  out  1  valid with street_done; at least one player has 0 remaining
- busy  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, POST_SB, POST_BB, WAIT_ACT, DONE. Each state occupies exactly one cycle except WAIT_ACT and IDLE.
- Reset: state IDLE; all outputs 0; internal contrib[0..1] = 0, rem[0..1] = 0, acted[0..1] = 0, last_inc = BB_SIZE. Reset mid-street aborts with no further pulses.
- IDLE + start:
  - Clear contrib and acted; set last_inc = BB_SIZE; latch rem = stacks.
  - Next state is POST_SB if preflop = 1, else WAIT_ACT with actor = ~button.
  - start outside IDLE is ignored.
- POST_SB: make_bet for the button player with amount min(SB_SIZE, rem). Next state POST_BB.
- POST_BB: make_bet for ~button with amount min(BB_SIZE, rem). Next state WAIT_ACT with actor = button.
- Blind commits do not set acted.
- WAIT_ACT: acts only on an action_valid cycle. Let o = ~actor and diff = contrib[o] - contrib[actor].
  - Fold: fold_end = 1, winner = o. Go to DONE.
  - Check/call:
    - amount = min(diff, rem[actor]). make_bet is pulsed only if amount > 0.
    - Set acted[actor].
    - The street ends if, after this action, contributions are equal and both acted, or either rem = 0.
    - Otherwise actor toggles.
  - Raise: legal iff raise_to > contrib[o], raise_to <= contrib[actor] + rem[actor], and (raise_to >= min_raise_to OR raise_to == contrib[actor] + rem[actor]).
    - If legal: make_bet with amount = raise_to - contrib[actor].
    - If raise_to - contrib[o] >= last_inc, set last_inc to that value.
    - Set acted[actor], clear acted[o], toggle actor.
  - Illegal raise, action 3, or a raise when rem[o] = 0: action_error pulse; no other state change.
- Combinational outputs:
  - min_raise_to = max(contrib) + last_inc.
  - call_amt = min(diff, rem[actor]).
- Bookkeeping:
  - The make_bet cycle also updates contrib += amount and rem -= amount.
  - street_pot = contrib[0] + contrib[1]. No overflow is possible, since the total is bounded by the sum of stacks < 2^MAX_STACK_W (caller guarantee).
- make_bet, bet_player and bet_amount are registered and valid in the same cycle.
- Action latency: action_valid in cycle N gives make_bet in N+1, plus street_done in N+1 when the street ends. The FSM is in DONE during N+1 and IDLE in N+2.
- DONE: street_done pulses. fold_end, winner and all_in hold until the next accepted start. Then IDLE.
- action_valid outside WAIT_ACT is ignored with no error.
- action_valid in the same cycle as the transition into WAIT_ACT is processed normally.
- Pre-flop BB option: after SB completes, contributions are equal but acted[BB] = 0, so the BB acts next.

Test Plan:
- Pre-flop, button = 0, stacks 100/100; p1 call, p2 check → make_bet (0,1), (1,2), (0,1); then street_done, street_pot = 4, fold_end = 0.
- Post-flop, button = 1; p1 check, p2 raise_to 10, p1 call → actor starts at 0; bets (1,10), (0,10); street_done, pot = 20.
- Min-raise: pre-flop, p1 raise_to 3 → action_error (min_raise_to = 4); then raise_to 6 → last_inc = 4; p2 min_raise_to = 10.
- All-in short: stacks 5/100, pre-flop, p1 raise_to 5 (< min 4? no, legal) then p2 call → street_done, all_in = 1. A separate p1 raise attempt with raise_to 4 then raise_to 5 is accepted as all-in even below min.
- Fold: post-flop, p1 raise_to 8, p2 fold → street_done, fold_end = 1, winner = 0, no make_bet for p2.
- Reset asserted in WAIT_ACT mid-street → next cycle busy = 0, all outputs 0; a subsequent start with preflop = 1 posts blinds again.

Source files
------------

// File: rtl/heads_up_betting_ctrl.sv
// heads_up_betting_ctrl: sequences one heads-up betting street, posting blinds and validating actions
module heads_up_betting_ctrl #(
    parameter int MAX_STACK_W = 11,
    parameter int SB_SIZE = 1,
    parameter int BB_SIZE = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   preflop,
    input  logic                   button,
    input  logic [MAX_STACK_W-1:0] stack_p1,
    input  logic [MAX_STACK_W-1:0] stack_p2,
    input  logic                   action_valid,
    input  logic [1:0]             action,
    input  logic [MAX_STACK_W-1:0] raise_to,
    output logic                   actor,
    output logic [MAX_STACK_W-1:0] call_amt,
    output logic [MAX_STACK_W-1:0] min_raise_to,
    output logic                   make_bet,
    output logic                   bet_player,
    output logic [MAX_STACK_W-1:0] bet_amount,
    output logic [MAX_STACK_W-1:0] street_pot,
    output logic                   action_error,
    output logic                   street_done,
    output logic                   fold_end,
    output logic                   winner,
    output logic                   all_in,
    output logic                   busy
);
    localparam logic [MAX_STACK_W-1:0] SB = MAX_STACK_W'(SB_SIZE);
    localparam logic [MAX_STACK_W-1:0] BB = MAX_STACK_W'(BB_SIZE);
    typedef enum logic [2:0] {IDLE, POST_SB, POST_BB, WAIT_ACT, DONE} state_t;
    state_t state;
    logic [MAX_STACK_W-1:0] contrib [2];
    logic [MAX_STACK_W-1:0] rem [2];
    logic [1:0] acted;
    logic [MAX_STACK_W-1:0] last_inc;
    logic btn;
    logic o;
    logic [MAX_STACK_W-1:0] c_a, c_o, r_a, r_o, diff, call_i, cap, max_c, mrt, raise_inc, sb_amt, bb_amt;
    logic raise_ok, call_end;
    logic bet_en, bet_p;
    logic [MAX_STACK_W-1:0] bet_amt;
    assign o = ~actor;
    assign busy = state != IDLE;
    assign street_pot = contrib[0] + contrib[1];
    // outputs stay quiet while idle so the reset/idle state reads as all zeros
    assign min_raise_to = busy ? mrt : '0;
    assign call_amt = busy ? call_i : '0;
    // betting arithmetic seen from the current actor's point of view
    always_comb begin
        c_a = contrib[actor];
        c_o = contrib[o];
        r_a = rem[actor];
        r_o = rem[o];
        diff = c_o > c_a ? c_o - c_a : '0;
        call_i = diff < r_a ? diff : r_a;
        cap = c_a + r_a;
        max_c = contrib[0] > contrib[1] ? contrib[0] : contrib[1];
        mrt = max_c + last_inc;
        raise_inc = raise_to - c_o;
        raise_ok = raise_to > c_o && raise_to <= cap && (raise_to >= mrt || raise_to == cap) && r_o != '0;
        call_end = (c_a + call_i == c_o && acted[o]) || r_a == call_i || r_o == '0;
        sb_amt = rem[btn] < SB ? rem[btn] : SB;
        bb_amt = rem[~btn] < BB ? rem[~btn] : BB;
    end
    // chip commit selected this cycle: blinds, a non-zero call, or a legal raise
    always_comb begin
        bet_en = state == POST_SB || state == POST_BB ||
                 (state == WAIT_ACT && action_valid &&
                  ((action == 2'd0 && call_i != '0) || (action == 2'd1 && raise_ok)));
        bet_p = state == POST_SB ? btn : state == POST_BB ? ~btn : actor;
        bet_amt = state == POST_SB ? sb_amt : state == POST_BB ? bb_amt :
                  action == 2'd1 ? raise_to - c_a : call_i;
    end
    // street FSM with registered pulses and bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            contrib[0] <= '0;
            contrib[1] <= '0;
            rem[0] <= '0;
            rem[1] <= '0;
            acted <= '0;
            last_inc <= BB;
            btn <= 1'b0;
            actor <= 1'b0;
            make_bet <= 1'b0;
            bet_player <= 1'b0;
            bet_amount <= '0;
            action_error <= 1'b0;
            street_done <= 1'b0;
            fold_end <= 1'b0;
            winner <= 1'b0;
            all_in <= 1'b0;
        end else begin
            make_bet <= bet_en;
            action_error <= 1'b0;
            street_done <= 1'b0;
            if (bet_en) begin
                bet_player <= bet_p;
                bet_amount <= bet_amt;
                contrib[bet_p] <= contrib[bet_p] + bet_amt;
                rem[bet_p] <= rem[bet_p] - bet_amt;
            end
            case (state)
                IDLE: if (start) begin
                    contrib[0] <= '0;
                    contrib[1] <= '0;
                    rem[0] <= stack_p1;
                    rem[1] <= stack_p2;
                    acted <= '0;
                    last_inc <= BB;
                    btn <= button;
                    actor <= ~button;
                    fold_end <= 1'b0;
                    winner <= 1'b0;
                    all_in <= 1'b0;
                    state <= preflop ? POST_SB : WAIT_ACT;
                end
                POST_SB: state <= POST_BB;
                POST_BB: begin
                    actor <= btn;
                    state <= WAIT_ACT;
                end
                WAIT_ACT: if (action_valid) begin
                    if (action == 2'd2) begin
                        fold_end <= 1'b1;
                        winner <= o;
                        all_in <= r_a == '0 || r_o == '0;
                        street_done <= 1'b1;
                        state <= DONE;
                    end else if (action == 2'd0) begin
                        acted[actor] <= 1'b1;
                        if (call_end) begin
                            all_in <= r_a == call_i || r_o == '0;
                            street_done <= 1'b1;
                            state <= DONE;
                        end else begin
                            actor <= o;
                        end
                    end else if (action == 2'd1 && raise_ok) begin
                        if (raise_inc >= last_inc) last_inc <= raise_inc;
                        acted[actor] <= 1'b1;
                        acted[o] <= 1'b0;
                        actor <= o;
                    end else begin
                        action_error <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_heads_up_betting_ctrl.sv
// tb_heads_up_betting_ctrl: scoreboard bench for the heads-up betting street controller
module tb_heads_up_betting_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, preflop = 1'b0, button = 1'b0;
    logic [10:0] stack_p1 = '0, stack_p2 = '0;
    logic action_valid = 1'b0;
    logic [1:0] action = '0;
    logic [10:0] raise_to = '0;
    logic actor, make_bet, bet_player, action_error, street_done, fold_end, winner, all_in, busy;
    logic [10:0] call_amt, min_raise_to, bet_amount, street_pot;

    heads_up_betting_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .preflop(preflop), .button(button),
        .stack_p1(stack_p1), .stack_p2(stack_p2), .action_valid(action_valid),
        .action(action), .raise_to(raise_to), .actor(actor), .call_amt(call_amt),
        .min_raise_to(min_raise_to), .make_bet(make_bet), .bet_player(bet_player),
        .bet_amount(bet_amount), .street_pot(street_pot), .action_error(action_error),
        .street_done(street_done), .fold_end(fold_end), .winner(winner), .all_in(all_in),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // kind: 0 = bet, 1 = street done (amt carries pot), 2 = action error
    typedef struct packed {
        logic [1:0] kind;
        logic p;
        logic [10:0] amt;
        logic fe;
        logic w;
        logic ai;
    } exp_t;
    exp_t q[$];
    int total = 0;
    int bad = 0;

    task automatic push(input int kind, input int p, input int amt, input int fe, input int w, input int ai);
        exp_t e;
        e.kind = 2'(kind);
        e.p = 1'(p);
        e.amt = 11'(amt);
        e.fe = 1'(fe);
        e.w = 1'(w);
        e.ai = 1'(ai);
        q.push_back(e);
    endtask

    task automatic exp_bet(input int p, input int amt);
        push(0, p, amt, 0, 0, 0);
    endtask

    task automatic exp_done(input int pot, input int fe, input int w, input int ai);
        push(1, 0, pot, fe, w, ai);
    endtask

    task automatic exp_err();
        push(2, 0, 0, 0, 0, 0);
    endtask

    task automatic check_evt(input string name, input exp_t got);
        exp_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected event kind=%0d p=%0d amt=%0d fe=%0d w=%0d ai=%0d", name,
                     got.kind, got.p, got.amt, got.fe, got.w, got.ai);
        end else begin
            e = q.pop_front();
            if (e !== got) begin
                bad++;
                $display("FAIL %s: got kind=%0d p=%0d amt=%0d fe=%0d w=%0d ai=%0d, want kind=%0d p=%0d amt=%0d fe=%0d w=%0d ai=%0d",
                         name, got.kind, got.p, got.amt, got.fe, got.w, got.ai,
                         e.kind, e.p, e.amt, e.fe, e.w, e.ai);
            end
        end
    endtask

    // monitor: every output pulse must match the next expected event
    always @(negedge clk) begin
        if (make_bet) check_evt("bet", {2'd0, bet_player, bet_amount, 3'b000});
        if (action_error) check_evt("error", {2'd2, 1'b0, 11'd0, 3'b000});
        if (street_done) check_evt("done", {2'd1, 1'b0, street_pot, fold_end, winner, all_in});
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic pf, input logic b, input int s1, input int s2);
        start = 1'b1;
        preflop = pf;
        button = b;
        stack_p1 = 11'(s1);
        stack_p2 = 11'(s2);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic act(input int a, input int rt);
        action_valid = 1'b1;
        action = 2'(a);
        raise_to = 11'(rt);
        @(negedge clk);
        action_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        chk(name, int'(busy), 0);
    endtask

    initial begin
        skip(3);
        reset = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_make_bet", int'(make_bet), 0);
        chk("rst_min_raise", int'(min_raise_to), 0);
        chk("rst_call_amt", int'(call_amt), 0);
        chk("rst_pot", int'(street_pot), 0);
        chk("rst_actor", int'(actor), 0);
        chk("rst_done", int'(street_done), 0);

        // pre-flop limp and BB check
        exp_bet(0, 1); exp_bet(1, 2); exp_bet(0, 1); exp_done(4, 0, 0, 0);
        do_start(1, 0, 100, 100);
        skip(2);
        chk("t1_actor", int'(actor), 0);
        chk("t1_call", int'(call_amt), 1);
        chk("t1_minr", int'(min_raise_to), 4);
        act(0, 0);
        chk("t1_bb_option", int'(actor), 1);
        chk("t1_call2", int'(call_amt), 0);
        act(0, 0);
        wait_idle("t1_idle");

        // post-flop check, raise, call
        exp_bet(1, 10); exp_bet(0, 10); exp_done(20, 0, 0, 0);
        do_start(0, 1, 100, 100);
        chk("t2_actor", int'(actor), 0);
        act(0, 0);
        chk("t2_actor2", int'(actor), 1);
        act(1, 10);
        chk("t2_call", int'(call_amt), 10);
        act(0, 0);
        wait_idle("t2_idle");

        // minimum raise enforcement, then fold
        exp_bet(0, 1); exp_bet(1, 2); exp_err(); exp_bet(0, 5); exp_done(8, 1, 0, 0);
        do_start(1, 0, 100, 100);
        skip(2);
        act(1, 3);
        chk("t3_actor_kept", int'(actor), 0);
        act(1, 6);
        chk("t3_minr", int'(min_raise_to), 10);
        chk("t3_actor", int'(actor), 1);
        act(2, 0);
        wait_idle("t3_idle");

        // short stack shoves and is called
        exp_bet(0, 1); exp_bet(1, 2); exp_bet(0, 4); exp_bet(1, 3); exp_done(10, 0, 0, 1);
        do_start(1, 0, 5, 100);
        skip(2);
        act(1, 5);
        act(0, 0);
        wait_idle("t4a_idle");

        // all-in below min raise is legal; raise not above opponent is not
        exp_bet(1, 1); exp_bet(0, 2); exp_bet(1, 3); exp_err(); exp_bet(0, 3); exp_bet(1, 1);
        exp_done(10, 0, 0, 1);
        do_start(1, 1, 5, 100);
        skip(2);
        chk("t4b_actor", int'(actor), 1);
        act(1, 4);
        chk("t4b_minr", int'(min_raise_to), 6);
        chk("t4b_call", int'(call_amt), 2);
        act(1, 4);
        act(1, 5);
        act(0, 0);
        wait_idle("t4b_idle");

        // post-flop bet then fold; fold flags persist in IDLE; idle actions ignored
        exp_bet(0, 8); exp_done(8, 1, 0, 0);
        do_start(0, 1, 100, 100);
        act(1, 8);
        act(2, 0);
        wait_idle("t5_idle");
        chk("t5_fold_hold", int'(fold_end), 1);
        chk("t5_winner_hold", int'(winner), 0);
        act(0, 0);
        skip(2);

        // reset mid-street, then a fresh pre-flop street
        exp_bet(0, 1); exp_bet(1, 2);
        do_start(1, 0, 100, 100);
        skip(2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_busy", int'(busy), 0);
        chk("t6_pot", int'(street_pot), 0);
        chk("t6_fold", int'(fold_end), 0);
        chk("t6_actor", int'(actor), 0);
        exp_bet(0, 1); exp_bet(1, 2); exp_done(3, 1, 1, 0);
        do_start(1, 0, 100, 100);
        skip(2);
        act(2, 0);
        wait_idle("t6_idle");
        skip(2);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
